// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 / SCHIP Dxyn sprite blitter: fetches sprite bytes and read-XOR-writes framebuffer pixels.
// Define CHIP8_SPRITE_WRAP_EN to wrap pixels at the framebuffer edges; otherwise they are clipped.
module chip8_sprite_blitter #(
  parameter int FB_W   = 64,
  parameter int FB_H   = 32,
  parameter int ADDR_W = 12
) (
  input  logic                      cpu_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                x,
  input  logic [7:0]                y,
  input  logic [3:0]                n,
  input  logic                      wide,
  input  logic [ADDR_W-1:0]         I_addr,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [7:0]                mem_readdata,
  output logic [$clog2(FB_W)-1:0]   fb_addr_x,
  output logic [$clog2(FB_H)-1:0]   fb_addr_y,
  input  logic                      fb_readdata,
  output logic                      fb_writedata,
  output logic                      fb_WE,
  output logic                      busy,
  output logic                      done,
  output logic                      collision
);

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PIX_RD,
    S_PIX_WR,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x0_q, x0_d;
  logic [YW-1:0]       y0_q, y0_d;
  logic [3:0]          last_row_q, last_row_d;
  logic                wide_q, wide_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          row_q, row_d;
  logic                byte_q, byte_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                coll_q, coll_d;

  logic [3:0]          col_off;
  logic [XW-1:0]       pix_x;
  logic [YW-1:0]       pix_y;
  logic                clip;
  logic                pix_on;
  logic [ADDR_W-1:0]   byte_addr;

  // Column offset inside the sprite: byte index selects the left/right half of a wide row.
  assign col_off = {byte_q, bit_q};

`ifdef CHIP8_SPRITE_WRAP_EN
  assign pix_x = x0_q + XW'(col_off);
  assign pix_y = y0_q + YW'(row_q);
  assign clip  = 1'b0;
`else
  localparam int CW = XW + 5;
  localparam int RW = YW + 5;
  logic [CW-1:0] col_full;
  logic [RW-1:0] row_full;
  assign col_full = CW'(x0_q) + CW'(col_off);
  assign row_full = RW'(y0_q) + RW'(row_q);
  assign clip     = (col_full >= CW'(FB_W)) || (row_full >= RW'(FB_H));
  assign pix_x    = col_full[XW-1:0];
  assign pix_y    = row_full[YW-1:0];
`endif

  assign pix_on    = shift_q[7] & ~clip;
  assign byte_addr = base_q + ADDR_W'(wide_q ? {row_q, byte_q} : {1'b0, row_q});
  assign busy      = (state_q != S_IDLE);
  assign collision = coll_q;

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    last_row_d   = last_row_q;
    wide_d       = wide_q;
    base_d       = base_q;
    row_d        = row_q;
    byte_d       = byte_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    coll_d       = coll_q;
    mem_addr     = '0;
    fb_addr_x    = '0;
    fb_addr_y    = '0;
    fb_writedata = 1'b0;
    fb_WE        = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d       = XW'(x);
          y0_d       = YW'(y);
          wide_d     = (n == 4'd0) && wide;
          last_row_d = ((n == 4'd0) && wide) ? 4'd15 : n - 4'd1;
          base_d     = I_addr;
          row_d      = '0;
          byte_d     = 1'b0;
          bit_d      = '0;
          coll_d     = 1'b0;
          state_d    = ((n == 4'd0) && !wide) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr = byte_addr;
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        mem_addr = byte_addr;
        shift_d  = mem_readdata;
        bit_d    = '0;
        state_d  = S_PIX_RD;
      end
      S_PIX_RD: begin
        mem_addr  = byte_addr;
        fb_addr_x = pix_x;
        fb_addr_y = pix_y;
        state_d   = S_PIX_WR;
      end
      S_PIX_WR: begin
        mem_addr  = byte_addr;
        fb_addr_x = pix_x;
        fb_addr_y = pix_y;
        if (pix_on) begin
          fb_WE        = 1'b1;
          fb_writedata = ~fb_readdata;
          if (fb_readdata) coll_d = 1'b1;
        end
        shift_d = {shift_q[6:0], 1'b0};
        if (bit_q == 3'd7) begin
          bit_d = '0;
          if (wide_q && !byte_q) begin
            byte_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            byte_d = 1'b0;
            if (row_q == last_row_q) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 4'd1;
              state_d = S_FETCH;
            end
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          state_d = S_PIX_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      last_row_q <= '0;
      wide_q     <= 1'b0;
      base_q     <= '0;
      row_q      <= '0;
      byte_q     <= 1'b0;
      bit_q      <= '0;
      shift_q    <= '0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      last_row_q <= last_row_d;
      wide_q     <= wide_d;
      base_q     <= base_d;
      row_q      <= row_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      coll_q     <= coll_d;
    end
  end

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Scoreboard bench for chip8_sprite_blitter: directed draws push expected fetches, writes and done events.
module tb_chip8_sprite_blitter;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x, y;
  logic [3:0]  n;
  logic        wide;
  logic [11:0] I_addr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata;
  logic [5:0]  fb_addr_x;
  logic [4:0]  fb_addr_y;
  logic        fb_readdata;
  logic        fb_writedata;
  logic        fb_WE;
  logic        busy;
  logic        done;
  logic        collision;

  always #5 cpu_clk = ~cpu_clk;

  chip8_sprite_blitter #(.FB_W(64), .FB_H(32), .ADDR_W(12)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .start(start), .x(x), .y(y), .n(n),
    .wide(wide), .I_addr(I_addr), .mem_addr(mem_addr), .mem_readdata(mem_readdata),
    .fb_addr_x(fb_addr_x), .fb_addr_y(fb_addr_y), .fb_readdata(fb_readdata),
    .fb_writedata(fb_writedata), .fb_WE(fb_WE), .busy(busy), .done(done),
    .collision(collision)
  );

  logic [7:0]  mem [4096];
  logic [63:0] fb [32] = '{default: '0};

  always @(posedge cpu_clk) begin
    mem_readdata <= mem[mem_addr];
    if (fb_WE) fb[fb_addr_y][fb_addr_x] <= fb_writedata;
  end
  assign fb_readdata = fb[fb_addr_y][fb_addr_x];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  logic [11:0] q_wr[$];
  int          q_fetch[$];
  int          q_done_cyc[$];
  int          q_done_col[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0 + 1);
    end
  endtask

  task automatic pw(input int px, input int py, input bit d);
    q_wr.push_back({6'(px), 5'(py), d});
  endtask

  task automatic pdone(input int c, input int col);
    q_done_cyc.push_back(c);
    q_done_col.push_back(col);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, a new fetch or done.
  logic        prev_busy = 1'b0;
  logic [11:0] prev_addr = '0;
  always @(negedge cpu_clk) begin
    logic [11:0] e;
    if (!reset) begin
      if (fb_WE) begin
        total++;
        if (q_wr.size() == 0) begin
          bad++;
          $display("FAIL write_extra: got (%0d,%0d,%0d) expected none", fb_addr_x, fb_addr_y, fb_writedata);
        end else begin
          e = q_wr.pop_front();
          if ({fb_addr_x, fb_addr_y, fb_writedata} != e) begin
            bad++;
            $display("FAIL write: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     fb_addr_x, fb_addr_y, fb_writedata, e[11:6], e[5:1], e[0]);
          end
        end
      end
      if (busy && !done && (!prev_busy || mem_addr != prev_addr)) begin
        if (q_fetch.size() == 0) chk("fetch_extra", int'(mem_addr), -1);
        else chk("fetch_addr", int'(mem_addr), q_fetch.pop_front());
      end
      if (done) begin
        if (q_done_cyc.size() == 0) chk("done_extra", cyc - t0 + 1, -1);
        else begin
          chk("done_cycle", cyc - t0 + 1, q_done_cyc.pop_front());
          chk("done_collision", int'(collision), q_done_col.pop_front());
        end
      end
    end
    prev_busy = busy;
    prev_addr = mem_addr;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_fb_addr_x"}, int'(fb_addr_x), 0);
    chk({tag, "_fb_addr_y"}, int'(fb_addr_y), 0);
    chk({tag, "_fb_writedata"}, int'(fb_writedata), 0);
    chk({tag, "_fb_WE"}, int'(fb_WE), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_collision"}, int'(collision), 0);
  endtask

  // Issues start, optionally pulses an ignored start at relative cycle ign, waits for done.
  task automatic draw(input int xx, input int yy, input int nn, input bit w, input int ia, input int ign);
    @(negedge cpu_clk);
    x = 8'(xx); y = 8'(yy); n = 4'(nn); wide = w; I_addr = 12'(ia);
    start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge cpu_clk);
      start = 1'b0;
      if (ign != 0 && (cyc - t0 + 1) == ign) begin
        start = 1'b1; x = 8'd0; y = 8'd0; n = 4'd2; I_addr = 12'h0F0F;
      end
      if (done) break;
      if (k == 999) chk("done_timeout", 0, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h0F0F] = 8'hAF;
    mem[12'h0F10] = 8'h68;
    mem[12'h300]  = 8'hFF;
    mem[12'h21F]  = 8'h01;
    reset = 1'b1; start = 1'b0; x = '0; y = '0; n = '0; wide = 1'b0; I_addr = '0;
    repeat (3) @(negedge cpu_clk);
    reset = 1'b0;
    @(negedge cpu_clk);
    check_idle("reset");

    // Basic draw onto a blank framebuffer
    q_fetch.push_back('h0F0F); q_fetch.push_back('h0F10);
    pw(3, 9, 1); pw(5, 9, 1); pw(7, 9, 1); pw(8, 9, 1); pw(9, 9, 1); pw(10, 9, 1);
    pw(4, 10, 1); pw(5, 10, 1); pw(7, 10, 1);
    pdone(37, 0);
    draw(3, 9, 2, 1'b0, 'h0F0F, 0);

    // Same sprite again clears every pixel and collides
    q_fetch.push_back('h0F0F); q_fetch.push_back('h0F10);
    pw(3, 9, 0); pw(5, 9, 0); pw(7, 9, 0); pw(8, 9, 0); pw(9, 9, 0); pw(10, 9, 0);
    pw(4, 10, 0); pw(5, 10, 0); pw(7, 10, 0);
    pdone(37, 1);
    draw(3, 9, 2, 1'b0, 'h0F0F, 0);
    repeat (3) @(negedge cpu_clk);
    chk("collision_held", int'(collision), 1);
    chk("busy_after_done", int'(busy), 0);

    // Reset at cycle 20 of an n=3 draw (blank sprite bytes)
    q_fetch.push_back('h400); q_fetch.push_back('h401);
    @(negedge cpu_clk);
    x = 8'd1; y = 8'd1; n = 4'd3; wide = 1'b0; I_addr = 12'h400;
    start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge cpu_clk);
      start = 1'b0;
      if ((cyc - t0 + 1) == 20) break;
    end
    reset = 1'b1;
    @(negedge cpu_clk);
    reset = 1'b0;
    check_idle("after_reset");
    @(negedge cpu_clk);
    q_fetch.push_back('h300);
    for (int c = 0; c < 8; c++) pw(c, 20, 1);
    pdone(19, 0);
    draw(0, 20, 1, 1'b0, 'h300, 0);

    // Right/bottom edge
    q_fetch.push_back('h300);
    pw(62, 31, 1); pw(63, 31, 1);
`ifdef CHIP8_SPRITE_WRAP_EN
    for (int c = 0; c < 6; c++) pw(c, 31, 1);
`endif
    pdone(19, 0);
    draw(62, 31, 1, 1'b0, 'h300, 0);

    // Wide 16x16 sprite: only the last byte's LSB is lit
    for (int a = 'h200; a <= 'h21F; a++) q_fetch.push_back(a);
    pw(55, 15, 1);
    pdone(577, 0);
    draw(40, 0, 0, 1'b1, 'h200, 0);

    // Empty sprite
    pdone(1, 0);
    draw(5, 5, 0, 1'b0, 'h300, 0);

    // Oversized origin with an ignored start mid-draw
    q_fetch.push_back('h300);
    for (int c = 8; c < 16; c++) pw(c, 8, 1);
    pdone(19, 0);
    draw(200, 40, 1, 1'b0, 'h300, 5);

    repeat (5) @(negedge cpu_clk);
    chk("pending_writes", q_wr.size(), 0);
    chk("pending_fetches", q_fetch.size(), 0);
    chk("pending_dones", q_done_cyc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_blitter.md
# chip8_sprite_blitter

Parametrised sprite-draw engine that executes the CHIP-8 Dxyn operation on behalf of the CPU, generalised to any framebuffer size and to the SCHIP 16x16 wide-sprite form. The CPU core hands it coordinates, row count and the I register on a `start` pulse and stalls until `done`. The blitter reads sprite bytes from main memory and performs a read-XOR-write on each framebuffer pixel. It reports the VF collision flag.

## Interface
- `FB_W`, 64: framebuffer width in pixels; power of two.
- `FB_H`, 32: framebuffer height in pixels; power of two.
- `ADDR_W`, 12: memory address width.
- `cpu_clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `x` in 8: Vx value; start column.
- `y` in 8: Vy value; start row.
- `n` in 4: sprite rows (1..15).
- `wide` in 1: with `n==0`, selects a 16x16 sprite.
- `I_addr` in `ADDR_W`: sprite base address.
- `mem_addr` out `ADDR_W`: sprite byte address.
- `mem_readdata` in 8: valid one cycle after `mem_addr`.
- `fb_addr_x` out `$clog2(FB_W)`: pixel column.
- `fb_addr_y` out `$clog2(FB_H)`: pixel row.
- `fb_readdata` in 1: combinational read of the addressed pixel.
- `fb_writedata` out 1: new pixel value.
- `fb_WE` out 1: pixel write strobe.
- `busy` out 1: high from the cycle after `start` until `done` inclusive.
- `done` out 1: one-cycle completion pulse.
- `collision` out 1: high if any lit pixel was cleared; held until the next `start`.

## Operation
- Geometry: `n` in 1..15 gives `n` rows of 1 byte. `n==0 && wide` gives 16 rows of 2 bytes, MSB-first and left-to-right. `n==0 && !wide` draws nothing.
- Byte address = `I_addr + row*bytes_per_row + byte`, truncated modulo 2^`ADDR_W`.
- Start origin is always reduced: `x0 = x mod FB_W`, `y0 = y mod FB_H`.
- FSM states: IDLE, FETCH, LATCH, PIX_RD, PIX_WR, DONE.
- IDLE: on `start`, latch inputs, clear `collision`, and go to FETCH. If the sprite is empty, go directly to DONE.
- FETCH: drive `mem_addr`, then go to LATCH.
- LATCH: capture `mem_readdata` into the shift register, then go to PIX_RD for bit 7.
- PIX_RD: drive pixel coordinates with `fb_WE=0`, then go to PIX_WR.
- PIX_WR: coordinates are held.
  - Sprite bit 1: `fb_WE=1`, `fb_writedata = ~fb_readdata`. If `fb_readdata` was 1, set `collision`.
  - Sprite bit 0: `fb_WE=0` and the pixel is left unchanged.
  - Next state is PIX_RD for the next bit. After bit 0, go to FETCH for the next byte or row, or to DONE after the last byte.
- DONE: `done=1`, then go to IDLE.
- `start` while not in IDLE is ignored.
- Pixel coordinate = origin + offset. The offset that crosses an edge is governed by `CHIP8_SPRITE_WRAP_EN` (see Configuration).

## Timing
- Reset values: FSM IDLE. `mem_addr`, `fb_addr_x`, `fb_addr_y`, `fb_writedata`, `fb_WE`, `busy`, `done` and `collision` are all 0.
- Outside PIX_RD/PIX_WR, `fb_addr_x`, `fb_addr_y`, `fb_writedata` and `fb_WE` are 0.
- Outside FETCH/LATCH/PIX_*, `mem_addr` is 0.
- Each byte costs 18 cycles: FETCH, LATCH, then 8 × (PIX_RD + PIX_WR).
- `start` sampled at edge 0 puts the FSM in FETCH during cycle 1.
- `done` is asserted in cycle `1 + 18*rows*bytes_per_row`.
  - `n=9`: done at cycle 163.
  - Wide sprite: done at cycle 577.
  - Empty sprite: done at cycle 1.
- `collision` is valid on the `done` cycle and stable afterwards.
- `reset` in any state: IDLE at the next edge, and all outputs return to their reset values in that cycle; any pixel write in progress is abandoned.
- `start` and `reset` in the same cycle: `reset` wins.

## Configuration
- `CHIP8_SPRITE_WRAP_EN` defined: pixel coordinates wrap modulo `FB_W`/`FB_H`. Every sprite bit of 1 is written.
- Not defined: pixels whose unreduced column is at least `FB_W`, or whose unreduced row is at least `FB_H`, are clipped.
  - Clipped pixels still take their 2 cycles, so timing is identical.
  - In PIX_WR they produce `fb_WE=0` and never set `collision`.

## Test plan
- Basic draw: FB_W=64, FB_H=32; `x=3, y=9, n=2, I_addr=0x0F0F`; bytes 0xAF, 0x68; blank framebuffer.
  - `mem_addr` = 0x0F0F, then 0x0F10.
  - Row 9: writes at columns 3,5,7,8,9,10, each with `fb_writedata=1`.
  - Row 10: writes at columns 4,5,7.
  - `done` at cycle 37; `collision=0`.
- Collision: repeat the basic draw on the resulting framebuffer.
  - Every write has `fb_writedata=0`; `collision=1` and held after `done`.
- Edge behaviour: `x=62, y=31, n=1`, byte 0xFF.
  - With WRAP_EN: writes at columns 62,63,0..5 in row 31.
  - Without WRAP_EN: writes only at columns 62 and 63.
  - Either build: `done` at cycle 19.
- Wide sprite: `n=0, wide=1, I_addr=0x200`.
  - 32 fetches at 0x200..0x21F; `done` at cycle 577.
  - `n=0, wide=0`: `done` at cycle 1, no fetch, no write.
- Oversized origin: `x=200, y=40` with FB_W=64, FB_H=32.
  - First pixel at (8,8).
- Reset mid-draw: assert `reset` at cycle 20 of a `n=3` draw.
  - Next cycle: all outputs 0, FSM in IDLE.
  - A `start` 2 cycles later begins cleanly with `collision=0`.
- Ignored start: pulse `start` while `busy`.
  - `done` timing and addresses are unchanged.
